// File: rtl/starfield_layers.sv
// Parallax starfield: per-layer LFSR star generator with frame-period speed control.
// Latency: one clock after an en cycle; no backpressure, state advances only on en.
module starfield_layers #(
    parameter int             H      = 800,
    parameter int             V      = 525,
    parameter int             LAYERS = 3,
    parameter int             LEN    = 25,
    parameter logic [LEN-1:0] TAPS   = 25'b1010000000000000000000000,
    parameter logic [LEN-1:0] SEED   = 25'b1111111111111110000000000,
    parameter logic [LEN-1:0] MASK   = 25'b1111111111111111111111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       vblank,
    input  logic       write,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic       sf_on,
    output logic [7:0] sf_star,
    output logic [1:0] sf_layer
);
    localparam int            CW = $clog2(H * V + 17 * H);
    localparam logic [CW-1:0] HV = CW'(H * V);

    function automatic logic [LEN-1:0] seed_of(input int k);
        logic [LEN-1:0] s;
        s = SEED ^ LEN'(k * 32'h0A5A5);
        if (s == '0) s = LEN'(1);
        return s;
    endfunction

    logic [7:0]     shadow_q [LAYERS];
    logic [7:0]     active_q [LAYERS];
    logic [CW-1:0]  cnt_q    [LAYERS];
    logic [CW-1:0]  per_q    [LAYERS];
    logic [2:0]     acc_q    [LAYERS];
    logic [LEN-1:0] lfsr_q   [LAYERS];
    logic           vblank_q;
    logic           sf_on_q;
    logic [7:0]     sf_star_q;
    logic [1:0]     sf_layer_q;

    logic [7:0]     sum_d    [LAYERS];
    logic [CW-1:0]  step_d   [LAYERS];
    logic [CW-1:0]  per_d    [LAYERS];
    logic [LEN-1:0] lfsr_d   [LAYERS];
    logic           wrap_d   [LAYERS];
    logic           on_d     [LAYERS];
    logic [7:0]     bright_d [LAYERS];
    logic           sf_on_d;
    logic [7:0]     sf_star_d;
    logic [1:0]     sf_layer_d;

    always_comb begin
        for (int k = 0; k < LAYERS; k++) begin
            // inc = sum>>3 spans 0..16, so a full 8-bit sum is needed
            sum_d[k]    = {5'd0, acc_q[k]} + {1'b0, active_q[k][6:0]};
            step_d[k]   = CW'(sum_d[k][7:3]) * CW'(H);
            per_d[k]    = active_q[k][7] ? (HV - step_d[k]) : (HV + step_d[k]);
            wrap_d[k]   = (cnt_q[k] == per_q[k] - CW'(1));
            lfsr_d[k]   = (cnt_q[k] == '0) ? seed_of(k)
                                           : {lfsr_q[k][LEN-2:0], ^(lfsr_q[k] & TAPS)};
            on_d[k]     = &(lfsr_q[k] | MASK);
            bright_d[k] = lfsr_q[k][7:0] >> k;
        end
    end

    // Walk from the deepest layer up so the lowest-index active layer wins.
    always_comb begin
        sf_on_d    = 1'b0;
        sf_star_d  = 8'd0;
        sf_layer_d = 2'd0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (on_d[k]) begin
                sf_on_d    = 1'b1;
                sf_star_d  = bright_d[k];
                sf_layer_d = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q   <= 1'b0;
            sf_on_q    <= 1'b0;
            sf_star_q  <= 8'd0;
            sf_layer_q <= 2'd0;
            for (int k = 0; k < LAYERS; k++) begin
                shadow_q[k] <= 8'd0;
                active_q[k] <= 8'd0;
                cnt_q[k]    <= '0;
                acc_q[k]    <= 3'd0;
                per_q[k]    <= HV;
                lfsr_q[k]   <= seed_of(k);
            end
        end else begin
            vblank_q <= vblank;
            for (int k = 0; k < LAYERS; k++) begin
                if (write && (32'(addr) == k)) shadow_q[k] <= data_in;
                // Same-cycle write loses to the commit: active takes the old shadow.
                if (vblank && !vblank_q) active_q[k] <= shadow_q[k];
                if (en) begin
                    lfsr_q[k] <= lfsr_d[k];
                    if (wrap_d[k]) begin
                        cnt_q[k] <= '0;
                        acc_q[k] <= sum_d[k][2:0];
                        per_q[k] <= per_d[k];
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CW'(1);
                    end
                end
            end
            if (en) begin
                sf_on_q    <= sf_on_d;
                sf_star_q  <= sf_star_d;
                sf_layer_q <= sf_layer_d;
            end
        end
    end

    assign sf_on    = sf_on_q;
    assign sf_star  = sf_star_q;
    assign sf_layer = sf_layer_q;
endmodule

// File: tb/tb_starfield_layers.sv
// Directed bench: u1 (1 layer) for timing/speed, u2/u3 (2 layers, all-on and sparse masks) for priority.
module tb_starfield_layers;
    localparam logic [24:0] S0   = 25'h1FFFC00;
    localparam logic [24:0] S1   = 25'h1FF59A5;
    localparam logic [24:0] TAPS = 25'h1400000;
    localparam logic [24:0] M3   = 25'h1FFFFFE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 0, vb_a = 0, wr_a = 0;
    logic [1:0] ad_a = 0;
    logic [7:0] d_a = 0;
    logic en_b = 0, vb_b = 0, wr_b = 0;
    logic [1:0] ad_b = 0;
    logic [7:0] d_b = 0;
    logic on_a, on_b2, on_b3;
    logic [7:0] star_a, star_b2, star_b3;
    logic [1:0] lay_a, lay_b2, lay_b3;

    int n_checks = 0;
    int n_fail = 0;
    logic [24:0] ma_lf;
    int ma_cnt;
    logic [24:0] mb_lf [2];
    int mb_cnt;
    logic [7:0] hist [96];

    always #5 clk = ~clk;

    starfield_layers #(.H(8), .V(4), .LAYERS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en_a), .vblank(vb_a), .write(wr_a), .addr(ad_a),
        .data_in(d_a), .sf_on(on_a), .sf_star(star_a), .sf_layer(lay_a));
    starfield_layers #(.H(8), .V(4), .LAYERS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en_b), .vblank(vb_b), .write(wr_b), .addr(ad_b),
        .data_in(d_b), .sf_on(on_b2), .sf_star(star_b2), .sf_layer(lay_b2));
    starfield_layers #(.H(8), .V(4), .LAYERS(2), .MASK(M3)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en_b), .vblank(vb_b), .write(wr_b), .addr(ad_b),
        .data_in(d_b), .sf_on(on_b3), .sf_star(star_b3), .sf_layer(lay_b3));

    function automatic logic [24:0] shl(input logic [24:0] s);
        return {s[23:0], ^(s & TAPS)};
    endfunction

    task automatic a_en();
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic write_a(input logic [7:0] d);
        ad_a = 2'd0; d_a = d; wr_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0;
    endtask

    task automatic vpulse_a();
        vb_a = 1'b1;
        @(posedge clk); #1;
        vb_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_to_wrap(input string nm, input int exp_len, input int exp_per);
        int cyc;
        cyc = 0;
        do begin
            a_en();
            cyc++;
        end while (u1.cnt_q[0] != 0 && cyc < 200);
        n_checks++;
        if (cyc !== exp_len) begin
            n_fail++;
            $display("FAIL %s_len: got %0d cycles, expected %0d", nm, cyc, exp_len);
        end
        n_checks++;
        if (int'(u1.per_q[0]) !== exp_per) begin
            n_fail++;
            $display("FAIL %s_per: got %0d, expected %0d", nm, u1.per_q[0], exp_per);
        end
    endtask

    task automatic b_step();
        logic e_on;
        logic [7:0] e_star;
        logic [1:0] e_lay;
        logic [7:0] b1;
        e_on = 0; e_star = 0; e_lay = 0;
        b1 = mb_lf[1][7:0];
        if (&(mb_lf[1] | M3)) begin e_on = 1; e_star = b1 >> 1; e_lay = 2'd1; end
        if (&(mb_lf[0] | M3)) begin e_on = 1; e_star = mb_lf[0][7:0]; e_lay = 2'd0; end
        en_b = 1'b1;
        @(posedge clk); #1;
        en_b = 1'b0;
        n_checks++;
        if ({on_b2, star_b2, lay_b2} !== {1'b1, mb_lf[0][7:0], 2'd0}) begin
            n_fail++;
            $display("FAIL all_on cnt=%0d: got on=%b star=%h layer=%0d, expected on=1 star=%h layer=0",
                     mb_cnt, on_b2, star_b2, lay_b2, mb_lf[0][7:0]);
        end
        n_checks++;
        if ({on_b3, star_b3, lay_b3} !== {e_on, e_star, e_lay}) begin
            n_fail++;
            $display("FAIL priority cnt=%0d: got on=%b star=%h layer=%0d, expected on=%b star=%h layer=%0d",
                     mb_cnt, on_b3, star_b3, lay_b3, e_on, e_star, e_lay);
        end
        mb_lf[0] = (mb_cnt == 0) ? S0 : shl(mb_lf[0]);
        mb_lf[1] = (mb_cnt == 0) ? S1 : shl(mb_lf[1]);
        mb_cnt = (mb_cnt == 31) ? 0 : mb_cnt + 1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({on_a, star_a, lay_a, on_b2, star_b2, lay_b2, on_b3, star_b3, lay_b3} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%h/%0d %b/%h/%0d %b/%h/%0d, expected all 0",
                     on_a, star_a, lay_a, on_b2, star_b2, lay_b2, on_b3, star_b3, lay_b3);
        end
        n_checks++;
        if (int'(u1.per_q[0]) !== 32) begin
            n_fail++;
            $display("FAIL reset_period: got %0d, expected 32", u1.per_q[0]);
        end
        n_checks++;
        if (u3.lfsr_q[0] !== S0 || u3.lfsr_q[1] !== S1) begin
            n_fail++;
            $display("FAIL reset_seeds: got %h %h, expected %h %h", u3.lfsr_q[0], u3.lfsr_q[1], S0, S1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_static();
        ma_cnt = 0;
        ma_lf = S0;
        for (int i = 0; i < 96; i++) begin
            logic [7:0] e;
            e = ma_lf[7:0];
            a_en();
            hist[i] = star_a;
            n_checks++;
            if ({on_a, star_a, lay_a} !== {1'b1, e, 2'd0}) begin
                n_fail++;
                $display("FAIL static_stream i=%0d: got on=%b star=%h layer=%0d, expected on=1 star=%h layer=0",
                         i, on_a, star_a, lay_a, e);
            end
            ma_lf = (ma_cnt == 0) ? S0 : shl(ma_lf);
            ma_cnt = (ma_cnt == 31) ? 0 : ma_cnt + 1;
        end
        for (int i = 32; i < 64; i++) begin
            n_checks++;
            if (hist[i] !== hist[i + 32]) begin
                n_fail++;
                $display("FAIL static_repeat i=%0d: got %h, expected %h", i + 32, hist[i + 32], hist[i]);
            end
        end
    endtask

    task automatic test_speed();
        write_a(8'h08);
        vpulse_a();
        n_checks++;
        if (u1.active_q[0] !== 8'h08) begin
            n_fail++;
            $display("FAIL speed_commit: got %h, expected 08", u1.active_q[0]);
        end
        run_to_wrap("fwd_first", 32, 40);
        run_to_wrap("fwd_next", 40, 40);
        write_a(8'h88);
        vpulse_a();
        run_to_wrap("rev_first", 40, 24);
        run_to_wrap("rev_next", 24, 24);
    endtask

    task automatic test_fraction();
        write_a(8'h01);
        vpulse_a();
        run_to_wrap("frac_1", 24, 32);
        for (int j = 2; j <= 8; j++) run_to_wrap("frac_n", 32, (j == 8) ? 40 : 32);
        run_to_wrap("frac_9", 40, 32);
    endtask

    task automatic test_same_cycle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ad_a = 2'd0; d_a = 8'h10; wr_a = 1'b1; vb_a = 1'b1;
        @(posedge clk); #1;
        wr_a = 1'b0;
        n_checks++;
        if (u1.active_q[0] !== 8'h00 || u1.shadow_q[0] !== 8'h10) begin
            n_fail++;
            $display("FAIL same_cycle: got active=%h shadow=%h, expected 00 10", u1.active_q[0], u1.shadow_q[0]);
        end
        @(posedge clk); #1;
        vb_a = 1'b0;
        n_checks++;
        if (u1.active_q[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL held_vblank: got %h, expected 00", u1.active_q[0]);
        end
        @(posedge clk); #1;
        vpulse_a();
        n_checks++;
        if (u1.active_q[0] !== 8'h10) begin
            n_fail++;
            $display("FAIL next_rise: got %h, expected 10", u1.active_q[0]);
        end
        run_to_wrap("speed10", 32, 48);
    endtask

    task automatic test_layers();
        mb_cnt = 0;
        mb_lf[0] = S0;
        mb_lf[1] = S1;
        for (int i = 0; i < 70; i++) b_step();
    endtask

    task automatic test_reset_midframe();
        ad_b = 2'd0; d_b = 8'h20; wr_b = 1'b1;
        @(posedge clk); #1;
        wr_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_en();
            b_step();
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({on_a, star_a, lay_a, on_b2, star_b2, lay_b2, on_b3, star_b3, lay_b3} !== 33'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b/%h/%0d %b/%h/%0d %b/%h/%0d, expected all 0",
                     on_a, star_a, lay_a, on_b2, star_b2, lay_b2, on_b3, star_b3, lay_b3);
        end
        n_checks++;
        if (u1.cnt_q[0] !== 8'd0 || int'(u1.per_q[0]) !== 32 || u2.shadow_q[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: got cnt=%0d per=%0d shadow=%h, expected 0 32 00",
                     u1.cnt_q[0], u1.per_q[0], u2.shadow_q[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mb_cnt = 0;
        mb_lf[0] = S0;
        mb_lf[1] = S1;
        b_step();
        ad_b = 2'd3; d_b = 8'h55; wr_b = 1'b1;
        @(posedge clk); #1;
        wr_b = 1'b0;
        vb_b = 1'b1;
        @(posedge clk); #1;
        vb_b = 1'b0;
        n_checks++;
        if ({u2.shadow_q[0], u2.shadow_q[1], u2.active_q[0], u2.active_q[1]} !== 32'd0) begin
            n_fail++;
            $display("FAIL addr3_ignored: got shadow=%h,%h active=%h,%h, expected all 00",
                     u2.shadow_q[0], u2.shadow_q[1], u2.active_q[0], u2.active_q[1]);
        end
        for (int i = 0; i < 40; i++) b_step();
    endtask

    initial begin
        test_reset();
        test_static();
        test_speed();
        test_fraction();
        test_same_cycle();
        test_layers();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
